bram_port_arbiter: RTL and testbench

Shares the data port (port B) of the unified dual-port instruction/data BRAM between two requesters. Master 0 is the CPU FSM's data-memory interface. Master 1 is the memory-display/debug reader driven by the show-memory mode. Master 0 has fixed priority, with an anti-starvation override for master 1, and read data is returned with a one-cycle BRAM latency tagged to the master that issued the read. The block sits between the FSM / display logic and the BRAM port B pins, in the `slow_clk` domain.

---
 rtl/bram_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Port-B arbiter for the shared instruction/data BRAM: fixed priority to the CPU
// data interface (m0) with an anti-starvation boost for the display reader (m1).
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_din,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_din,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [15:0]           conflict_cnt
);

  typedef enum logic [0:0] {
    FAVOR0 = 1'b0,
    FAVOR1 = 1'b1
  } state_e;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_owner_q, rd_owner_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Grant selection: boosted m1 first, then m0, then m1; nothing while in reset.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end else if ((state_q == FAVOR1) && m1_req) begin
      m1_gnt = 1'b1;
    end else if (m0_req) begin
      m0_gnt = 1'b1;
    end else if (m1_req) begin
      m1_gnt = 1'b1;
    end else begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end
  end

  // Port-B mux: idle bus is driven to all zeros.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case ({m1_gnt, m0_gnt})
      2'b01: begin
        mem_we   = m0_we;
        mem_addr = m0_addr;
        mem_din  = m0_din;
      end
      2'b10: begin
        mem_we   = m1_we;
        mem_addr = m1_addr;
        mem_din  = m1_din;
      end
      default: begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
      end
    endcase
  end

  assign mem_en = m0_gnt | m1_gnt;

  // Next-state: starvation counter, priority state, read tag, conflict counter.
  always_comb begin
    wait_cnt_d     = 4'd0;
    state_d        = state_q;
    conflict_cnt_d = conflict_cnt_q;
    rd_pend_d      = mem_en & ~mem_we;
    rd_owner_d     = m1_gnt;

    if (m1_req && !m1_gnt) begin
      if (wait_cnt_q >= WAIT_LIMIT) begin
        wait_cnt_d = WAIT_LIMIT;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end else begin
      wait_cnt_d = 4'd0;
    end

    // A dropped m1 request forfeits the boost just like a served one.
    case (state_q)
      FAVOR0: begin
        if (m1_req && !m1_gnt && (wait_cnt_d == WAIT_LIMIT)) begin
          state_d = FAVOR1;
        end else begin
          state_d = FAVOR0;
        end
      end
      FAVOR1: begin
        if (m1_gnt || !m1_req) begin
          state_d = FAVOR0;
        end else begin
          state_d = FAVOR1;
        end
      end
      default: state_d = FAVOR0;
    endcase

    if (m0_req && m1_req && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FAVOR0;
      wait_cnt_q     <= 4'd0;
      rd_pend_q      <= 1'b0;
      rd_owner_q     <= 1'b0;
      conflict_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      rd_pend_q      <= rd_pend_d;
      rd_owner_q     <= rd_owner_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Read response steering; a read tagged just before reset is suppressed.
  always_comb begin
    m0_rvalid = rd_pend_q & ~rd_owner_q & ~rst;
    m1_rvalid = rd_pend_q &  rd_owner_q & ~rst;
    m0_rdata  = '0;
    m1_rdata  = '0;
    if (m0_rvalid) begin
      m0_rdata = mem_dout;
    end else begin
      m0_rdata = '0;
    end
    if (m1_rvalid) begin
      m1_rdata = mem_dout;
    end else begin
      m1_rdata = '0;
    end
  end

  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model, per-cycle reference monitor with a
// read-response scoreboard, and directed scenario tasks.
module tb_bram_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          preload;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_din, m1_din;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic [15:0]   conflict_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .conflict_cnt(conflict_cnt)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = DW'(a) * 16'd37 + 16'h0A00;
    if (a == 9'h005) v = 16'h00FF;
    return v;
  endfunction

  // Write-first BRAM with one-cycle read latency
  logic [DW-1:0] bram [0:511];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) bram[i] <= init_val(AW'(i));
    end else if (mem_en) begin
      if (mem_we) begin
        bram[mem_addr] <= mem_din;
        mem_dout       <= mem_din;
      end else begin
        mem_dout <= bram[mem_addr];
      end
    end
  end

  logic [DW-1:0] ref_wr [int];
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return init_val(a);
  endfunction

  typedef struct {
    int            due;
    logic          owner;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  int          cyc      = 0;
  logic        mdl_fav1 = 1'b0;
  int          mdl_wait = 0;
  logic [15:0] mdl_conf = 16'd0;
  logic        last_g0  = 1'b0;
  logic        last_g1  = 1'b0;

  // Reference monitor: grants, bus mux, conflict count, read responses
  always @(negedge clk) begin : mon
    logic eg0, eg1, een, ewe, ev0, ev1;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edin, ed0, ed1;
    int nw;
    rsp_t e;
    cyc = cyc + 1;
    eg0 = 1'b0; eg1 = 1'b0;
    if (!rst) begin
      if (mdl_fav1 && m1_req) eg1 = 1'b1;
      else if (m0_req) eg0 = 1'b1;
      else if (m1_req) eg1 = 1'b1;
    end
    een = eg0 | eg1;
    ewe = eg0 ? m0_we : (eg1 ? m1_we : 1'b0);
    eaddr = eg0 ? m0_addr : (eg1 ? m1_addr : '0);
    edin  = eg0 ? m0_din : (eg1 ? m1_din : '0);

    checks++;
    if ({m0_gnt, m1_gnt} !== {eg0, eg1}) begin
      failures++;
      $display("FAIL mon_gnt cyc=%0d got m0=%b m1=%b want m0=%b m1=%b", cyc, m0_gnt, m1_gnt, eg0, eg1);
    end
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_din} !== {een, ewe, eaddr, edin}) begin
      failures++;
      $display("FAIL mon_bus cyc=%0d got en=%b we=%b a=%h d=%h want en=%b we=%b a=%h d=%h",
               cyc, mem_en, mem_we, mem_addr, mem_din, een, ewe, eaddr, edin);
    end
    checks++;
    if (conflict_cnt !== mdl_conf) begin
      failures++;
      $display("FAIL mon_conflict cyc=%0d got %0d want %0d", cyc, conflict_cnt, mdl_conf);
    end

    ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (!rst) begin
        if (e.owner) begin ev1 = 1'b1; ed1 = e.data; end
        else begin ev0 = 1'b1; ed0 = e.data; end
      end
    end
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {ev0, ev1, ed0, ed1}) begin
      failures++;
      $display("FAIL mon_rsp cyc=%0d got v=%b%b d0=%h d1=%h want v=%b%b d0=%h d1=%h",
               cyc, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, ev0, ev1, ed0, ed1);
    end

    if (een && !ewe) sb.push_back('{cyc + 1, eg1, ref_rd(eaddr)});
    if (een && ewe) ref_wr[int'(eaddr)] = edin;

    if (rst) begin
      mdl_fav1 = 1'b0; mdl_wait = 0; mdl_conf = 16'd0;
    end else begin
      if (m0_req && m1_req && mdl_conf != 16'hFFFF) mdl_conf = mdl_conf + 16'd1;
      nw = (m1_req && !eg1) ? ((mdl_wait + 1 > MW) ? MW : mdl_wait + 1) : 0;
      if (!mdl_fav1) mdl_fav1 = m1_req && !eg1 && (nw == MW);
      else mdl_fav1 = !(eg1 || !m1_req);
      mdl_wait = nw;
    end
    last_g0 = eg0;
    last_g1 = eg1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_din = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_din = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req = 1'b1; m0_addr = 9'h001;
    m1_req = 1'b1; m1_addr = 9'h002;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt, mem_en, m0_rvalid, m1_rvalid} !== 5'b00000 || conflict_cnt !== 16'd0) begin
        failures++;
        $display("FAIL reset_outputs got gnt=%b%b en=%b rv=%b%b cnt=%0d want all 0",
                 m0_gnt, m1_gnt, mem_en, m0_rvalid, m1_rvalid, conflict_cnt);
      end
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_grant got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_single_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h005;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin
      failures++;
      $display("FAIL single_read_gnt got %b want 1", m0_gnt);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 16'h00FF || m1_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_read_data got v0=%b d0=%h v1=%b want v0=1 d0=00ff v1=0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_write_read();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'h1F0; m1_din = 16'h1234;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'h1F0 || mem_din !== 16'h1234) begin
      failures++;
      $display("FAIL write_cycle got gnt=%b we=%b a=%h d=%h want 1 1 1f0 1234", m1_gnt, mem_we, mem_addr, mem_din);
    end
    next_cycle();
    m1_we = 1'b0; m1_din = '0;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL read_back_gnt got gnt=%b we=%b want 1 0", m1_gnt, mem_we);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 16'h1234) begin
      failures++;
      $display("FAIL read_back_data got v1=%b d1=%h want 1 1234", m1_rvalid, m1_rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic want1;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = AW'(c);
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = AW'(9'h100 + c);
      want1 = ((c % 5) == 4);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== {~want1, want1}) begin
        failures++;
        $display("FAIL starve_gnt c=%0d got m0=%b m1=%b want m0=%b m1=%b", c, m0_gnt, m1_gnt, ~want1, want1);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (conflict_cnt !== 16'd15) begin
      failures++;
      $display("FAIL starve_conflict got %0d want 15", conflict_cnt);
    end
    next_cycle();
  endtask

  task automatic test_boost_forfeit();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = AW'(9'h020 + c);
      m1_req = (c < 4 || c >= 6); m1_we = 1'b0; m1_addr = 9'h0C0;
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== {c != 10, c == 10}) begin
        failures++;
        $display("FAIL forfeit_gnt c=%0d got m0=%b m1=%b want m0=%b m1=%b", c, m0_gnt, m1_gnt, c != 10, c == 10);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h1F0;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midrst_gnt got %b want 1", m1_gnt);
    end
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 16'h0000) begin
      failures++;
      $display("FAIL midrst_rvalid got v1=%b d1=%h want 0 0000", m1_rvalid, m1_rdata);
    end
    next_cycle();
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 9'h003;
    m1_req = 1'b1; m1_addr = 9'h004;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0 || {m0_gnt, m1_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL midrst_after got v1=%b gnt=%b%b want v1=0 gnt=10", m1_rvalid, m0_gnt, m1_gnt);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      if (!(m0_req && !last_g0)) begin
        m0_req = 1'($urandom_range(0, 1));
        m0_we = ($urandom_range(0, 2) == 0);
        m0_addr = AW'($urandom_range(0, 15));
        m0_din = DW'($urandom);
      end
      if (!(m1_req && !last_g1)) begin
        m1_req = 1'($urandom_range(0, 1));
        m1_we = ($urandom_range(0, 2) == 0);
        m1_addr = AW'($urandom_range(0, 15));
        m1_din = DW'($urandom);
      end
      @(negedge clk);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    preload = 1'b1;
    idle_inputs();
    next_cycle();
    preload = 1'b0;
    test_reset();
    test_single_read();
    test_write_read();
    test_starvation();
    test_boost_forfeit();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
